// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multicycle core: walks one instruction through the
// shared ALU, extender, register file and unified memory port.
module multicycle_ctrl_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       cond_ex,
    input  logic       mem_ready,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       aluop,
    output logic [1:0] resultsrc,
    output logic [1:0] immsrc,
    output logic       regwrite,
    output logic       memwrite,
    output logic       illegal,
    output logic       retire,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    state_t state_q;
    state_t state_d;

    // cmd bits [2:1] never influence sequencing; only the compare group matters.
    logic funct_unused;
    assign funct_unused = ^funct[2:1];

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // NOTE: every comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = (mem_ready || !cond_ex) ? FETCH : MEMWRITE;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        adrsrc    = 1'b0;
        alusrca   = 1'b0;
        alusrcb   = 2'b00;
        aluop     = 1'b0;
        resultsrc = 2'b00;
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        illegal   = 1'b0;
        retire    = 1'b0;
        immsrc    = (op == 2'b11) ? 2'b00 : op;
        case (state_q)
            FETCH: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                irwrite   = mem_ready;
                pcwrite   = mem_ready;
            end
            DECODE: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                illegal   = (op == 2'b11);
                retire    = (op == 2'b11);
            end
            MEMADR:   alusrcb = 2'b01;
            MEMREAD:  adrsrc  = 1'b1;
            MEMWB: begin
                resultsrc = 2'b01;
                regwrite  = cond_ex;
                retire    = 1'b1;
            end
            MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = cond_ex;
                retire   = mem_ready || !cond_ex;
            end
            EXECUTER: aluop = 1'b1;
            EXECUTEI: begin
                aluop   = 1'b1;
                alusrcb = 2'b01;
            end
            ALUWB: begin
                // TST/TEQ/CMP/CMN only update flags, never the register file.
                regwrite = cond_ex && (funct[4:3] != 2'b10);
                retire   = 1'b1;
            end
            BRANCH: begin
                alusrcb   = 2'b01;
                resultsrc = 2'b10;
                pcwrite   = cond_ex;
                retire    = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            illegal  = 1'b0;
            retire   = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed, table-driven bench for multicycle_ctrl_fsm with hand-computed
// expected output words, plus hand-written reset-abort sequence.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic       cond_ex;
    logic       mem_ready;
    logic       irwrite, pcwrite, adrsrc, alusrca, aluop;
    logic [1:0] alusrcb, resultsrc, immsrc;
    logic       regwrite, memwrite, illegal, retire;
    logic [3:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .cond_ex   (cond_ex),
        .mem_ready (mem_ready),
        .irwrite   (irwrite),
        .pcwrite   (pcwrite),
        .adrsrc    (adrsrc),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .resultsrc (resultsrc),
        .immsrc    (immsrc),
        .regwrite  (regwrite),
        .memwrite  (memwrite),
        .illegal   (illegal),
        .retire    (retire),
        .state     (state)
    );

    logic [18:0] outs;
    assign outs = {irwrite, pcwrite, adrsrc, alusrca, alusrcb, aluop, resultsrc,
                   immsrc, regwrite, memwrite, illegal, retire, state};

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic        cond_ex;
        logic        mem_ready;
        logic [18:0] exp;
    } vec_t;

    vec_t vecs[$];

    // Packs an expected output word in the same field order as outs.
    function automatic logic [18:0] e(int st, int irw, int pcw, int adr, int asa, int asb,
                                      int aop, int rs, int imm, int rw, int mw, int ill, int ret);
        return {irw[0], pcw[0], adr[0], asa[0], asb[1:0], aop[0], rs[1:0], imm[1:0],
                rw[0], mw[0], ill[0], ret[0], st[3:0]};
    endfunction

    function automatic void add(string name, logic [1:0] o, logic [5:0] f, logic c, logic m,
                                logic [18:0] x);
        vec_t v;
        v.name = name; v.op = o; v.funct = f; v.cond_ex = c; v.mem_ready = m; v.exp = x;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (irw pcw adr asa asb aop rs imm rw mw ill ret state)",
                     name, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        op = v.op; funct = v.funct; cond_ex = v.cond_ex; mem_ready = v.mem_ready;
        #1;
        check(v.name, outs, v.exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ADD immediate, all ready
        add("addi_fetch",   2'b00, 6'b101000, 1, 1, e(0,1,1,0,1,2,0,2,0,0,0,0,0));
        add("addi_decode",  2'b00, 6'b101000, 1, 1, e(1,0,0,0,1,2,0,2,0,0,0,0,0));
        add("addi_execi",   2'b00, 6'b101000, 1, 1, e(7,0,0,0,0,1,1,0,0,0,0,0,0));
        add("addi_aluwb",   2'b00, 6'b101000, 1, 1, e(8,0,0,0,0,0,0,0,0,1,0,0,1));
        // LDR with two stall cycles in MEMREAD
        add("ldr_fetch",    2'b01, 6'b011001, 1, 1, e(0,1,1,0,1,2,0,2,1,0,0,0,0));
        add("ldr_decode",   2'b01, 6'b011001, 1, 1, e(1,0,0,0,1,2,0,2,1,0,0,0,0));
        add("ldr_memadr",   2'b01, 6'b011001, 1, 1, e(2,0,0,0,0,1,0,0,1,0,0,0,0));
        add("ldr_stall0",   2'b01, 6'b011001, 1, 0, e(3,0,0,1,0,0,0,0,1,0,0,0,0));
        add("ldr_stall1",   2'b01, 6'b011001, 1, 0, e(3,0,0,1,0,0,0,0,1,0,0,0,0));
        add("ldr_ready",    2'b01, 6'b011001, 1, 1, e(3,0,0,1,0,0,0,0,1,0,0,0,0));
        add("ldr_memwb",    2'b01, 6'b011001, 1, 1, e(4,0,0,0,0,0,0,1,1,1,0,0,1));
        // STR, cond passes, three stall cycles
        add("str_fetch",    2'b01, 6'b011000, 1, 1, e(0,1,1,0,1,2,0,2,1,0,0,0,0));
        add("str_decode",   2'b01, 6'b011000, 1, 1, e(1,0,0,0,1,2,0,2,1,0,0,0,0));
        add("str_memadr",   2'b01, 6'b011000, 1, 1, e(2,0,0,0,0,1,0,0,1,0,0,0,0));
        add("str_wait0",    2'b01, 6'b011000, 1, 0, e(5,0,0,1,0,0,0,0,1,0,1,0,0));
        add("str_wait1",    2'b01, 6'b011000, 1, 0, e(5,0,0,1,0,0,0,0,1,0,1,0,0));
        add("str_wait2",    2'b01, 6'b011000, 1, 0, e(5,0,0,1,0,0,0,0,1,0,1,0,0));
        add("str_ready",    2'b01, 6'b011000, 1, 1, e(5,0,0,1,0,0,0,0,1,0,1,0,1));
        // STR, cond fails: single MEMWRITE cycle despite mem_ready=0
        add("strnc_fetch",  2'b01, 6'b011000, 0, 1, e(0,1,1,0,1,2,0,2,1,0,0,0,0));
        add("strnc_decode", 2'b01, 6'b011000, 0, 1, e(1,0,0,0,1,2,0,2,1,0,0,0,0));
        add("strnc_memadr", 2'b01, 6'b011000, 0, 1, e(2,0,0,0,0,1,0,0,1,0,0,0,0));
        add("strnc_memwr",  2'b01, 6'b011000, 0, 0, e(5,0,0,1,0,0,0,0,1,0,0,0,1));
        // Branch taken, then not taken
        add("b_fetch",      2'b10, 6'b000000, 1, 1, e(0,1,1,0,1,2,0,2,2,0,0,0,0));
        add("b_decode",     2'b10, 6'b000000, 1, 1, e(1,0,0,0,1,2,0,2,2,0,0,0,0));
        add("b_taken",      2'b10, 6'b000000, 1, 1, e(9,0,1,0,0,1,0,2,2,0,0,0,1));
        add("bnt_fetch",    2'b10, 6'b000000, 0, 1, e(0,1,1,0,1,2,0,2,2,0,0,0,0));
        add("bnt_decode",   2'b10, 6'b000000, 0, 1, e(1,0,0,0,1,2,0,2,2,0,0,0,0));
        add("bnt_branch",   2'b10, 6'b000000, 0, 1, e(9,0,0,0,0,1,0,2,2,0,0,0,1));
        // CMP register form: no register write
        add("cmp_fetch",    2'b00, 6'b010101, 1, 1, e(0,1,1,0,1,2,0,2,0,0,0,0,0));
        add("cmp_decode",   2'b00, 6'b010101, 1, 1, e(1,0,0,0,1,2,0,2,0,0,0,0,0));
        add("cmp_execr",    2'b00, 6'b010101, 1, 1, e(6,0,0,0,0,0,1,0,0,0,0,0,0));
        add("cmp_aluwb",    2'b00, 6'b010101, 1, 1, e(8,0,0,0,0,0,0,0,0,0,0,0,1));
        // ADD register form: writes
        add("add_fetch",    2'b00, 6'b001000, 1, 1, e(0,1,1,0,1,2,0,2,0,0,0,0,0));
        add("add_decode",   2'b00, 6'b001000, 1, 1, e(1,0,0,0,1,2,0,2,0,0,0,0,0));
        add("add_execr",    2'b00, 6'b001000, 1, 1, e(6,0,0,0,0,0,1,0,0,0,0,0,0));
        add("add_aluwb",    2'b00, 6'b001000, 1, 1, e(8,0,0,0,0,0,0,0,0,1,0,0,1));
        // Undefined op, then FETCH held by mem_ready=0
        add("ill_fetch",    2'b11, 6'b000000, 1, 1, e(0,1,1,0,1,2,0,2,0,0,0,0,0));
        add("ill_decode",   2'b11, 6'b000000, 1, 1, e(1,0,0,0,1,2,0,2,0,0,0,1,1));
        for (int i = 0; i < 5; i++)
            add($sformatf("fetch_hold%0d", i), 2'b11, 6'b000000, 1, 0,
                e(0,0,0,0,1,2,0,2,0,0,0,0,0));

        // Reset asserted with mem_ready=1: enables must stay gated
        reset = 1'b1; op = 2'b00; funct = 6'b001000; cond_ex = 1'b1; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", outs, e(0,0,0,0,1,2,0,2,0,0,0,0,0));

        // Start an ADD register instruction, abort it in EXECUTER
        reset = 1'b0;
        #1;
        check("abort_fetch", outs, e(0,1,1,0,1,2,0,2,0,0,0,0,0));
        @(posedge clk); #1;
        check("abort_decode", outs, e(1,0,0,0,1,2,0,2,0,0,0,0,0));
        @(posedge clk); #1;
        check("abort_execr", outs, e(6,0,0,0,0,0,1,0,0,0,0,0,0));
        #2 reset = 1'b1;
        #1;
        check("reset_mid_exec", outs, e(0,0,0,0,1,2,0,2,0,0,0,0,0));
        @(posedge clk); #1;
        check("reset_no_aluwb", outs, e(0,0,0,0,1,2,0,2,0,0,0,0,0));
        reset = 1'b0;

        foreach (vecs[i]) step(vecs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Main control state machine that sequences the shared datapath over multiple cycles. The shared datapath is one ALU, the immediate extender, the register file and a single unified instruction/data memory port. It decodes op/funct from the latched instruction and drives the mux selects, immediate-source select and write enables. It stalls on a memory ready handshake. It replaces per-instruction single-cycle decode in the multicycle core variant.

Parameters:
None. State encoding is fixed, 4-bit binary: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.

Ports:
clk        in   1  system clock, rising edge
reset      in   1  asynchronous, active-high; forces state to FETCH
op         in   2  instr[27:26] from instruction register
funct      in   6  instr[25:20]: [5]=I, [4:1]=cmd, [0]=S/L
cond_ex    in   1  condition check passed (from condlogic)
mem_ready  in   1  memory access completes this cycle
irwrite    out  1  instruction register load enable
pcwrite    out  1  PC load enable
adrsrc     out  1  memory address select: 0=PC, 1=ALU result reg
alusrca    out  1  ALU A select: 0=Rn, 1=PC
alusrcb    out  2  ALU B select: 00=Rm, 01=extended imm, 10=const 4
aluop      out  1  0=force ADD, 1=decode from funct
resultsrc  out  2  00=ALUOut reg, 01=read data reg, 10=ALU result direct
immsrc     out  2  extender select
regwrite   out  1  register file write enable
memwrite   out  1  memory write enable
illegal    out  1  1-cycle pulse on undefined op
retire     out  1  1-cycle pulse on the last cycle of each instruction
state      out  4  current state (debug/verification)

Behaviour:
- Sequential element: a single 4-bit state register with asynchronous reset to FETCH. All outputs are combinational from state, op, funct, cond_ex and mem_ready (Moore plus gating).
- While reset=1, all write enables (irwrite, pcwrite, regwrite, memwrite), illegal and retire are 0. Selects take their FETCH values. State reads 0.
- Reset asserted mid-instruction aborts the instruction: state returns to FETCH immediately and no partial write occurs after the reset edge.
- Default for every output is 0 unless listed below.
- immsrc = op for op in {00,01,10}; op=11 gives 00. It is valid in every state.
- FETCH: adrsrc=0, alusrca=1, alusrcb=10, resultsrc=10. irwrite=pcwrite=mem_ready. mem_ready=1 goes to DECODE, else stay.
- DECODE: alusrca=1, alusrcb=10, resultsrc=10. Next state by op:
  - op=01 goes to MEMADR.
  - op=00 with funct[5]=1 goes to EXECUTEI; with funct[5]=0 goes to EXECUTER.
  - op=10 goes to BRANCH.
  - op=11: illegal=1, retire=1, go to FETCH.
- MEMADR: alusrcb=01. funct[0]=1 goes to MEMREAD, else MEMWRITE.
- MEMREAD: adrsrc=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: resultsrc=01, regwrite=cond_ex, retire=1, go to FETCH.
- MEMWRITE: adrsrc=1, memwrite=cond_ex, held every wait cycle.
  - mem_ready=1 gives retire=1 and goes to FETCH.
  - If cond_ex=0, go to FETCH in the same cycle regardless of mem_ready, with retire=1.
- EXECUTER: aluop=1, alusrcb=00, go to ALUWB.
- EXECUTEI: aluop=1, alusrcb=01, go to ALUWB.
- ALUWB: resultsrc=00, retire=1, go to FETCH.
  - regwrite = cond_ex AND NOT (funct[4:3]==2'b10). This suppresses the TST/TEQ/CMP/CMN write.
- BRANCH: alusrcb=01, resultsrc=10, pcwrite=cond_ex, retire=1, go to FETCH.
- Unused encodings 10–15 go to FETCH with all enables 0.
- Latency with mem_ready tied 1:
  - Data-processing: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - B: 3 cycles.
  - Each stall cycle adds 1.

Test Plan:
- Assert reset mid-EXECUTER, release; mem_ready=1, op=00, funct=6'b101000 (ADD imm) -> state 0 at reset; then 0,1,7,8; regwrite=1 only in ALUWB; irwrite only in the first cycle; immsrc=00; retire pulses once.
- LDR: op=01, funct=6'b011001, mem_ready low for 2 cycles in MEMREAD -> sequence 0,1,2,3,3,3,4; adrsrc=1 in MEMREAD; regwrite with resultsrc=01 in MEMWB; immsrc=01.
- STR: op=01, funct[0]=0, cond_ex=1, mem_ready=0 for 3 cycles -> memwrite=1 all 4 MEMWRITE cycles, retire on the ready cycle; repeat with cond_ex=0 -> memwrite never 1 and exit after 1 MEMWRITE cycle.
- Branch: op=10, cond_ex=1 then 0 -> states 0,1,9; pcwrite=1 in BRANCH only when cond_ex=1; immsrc=10.
- CMP register form: funct=6'b010101 -> regwrite=0 in ALUWB; same with funct=6'b001000 (ADD) -> regwrite=1.
- op=11 -> illegal=1 for exactly 1 cycle in DECODE, state returns to 0, no write enables asserted; FETCH with mem_ready=0 holds 5 cycles with irwrite=pcwrite=0.
